// File: rtl/controller_uart_tx_arbiter.sv
// controller_uart_tx_arbiter: round-robin, message-granular sharing of one UART TX.
// Optional inter-message idle gap: define CONTROLLER_UART_TX_GAP_EN.
// Ports: clk, reset (async, active-high); req_valid/req_data/req_last/req_ready per
// requester; tx_data/tx_write to UART, tx_busy from UART; grant_id, active, burst_trunc.
module controller_uart_tx_arbiter #(
   parameter  int NUM_REQ    = 2,
   parameter  int DATA_W     = 8,
   parameter  int MAX_BURST  = 16,
   parameter  int GAP_CYCLES = 4,
   localparam int GW         = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [NUM_REQ-1:0]        req_valid,
   input  logic [NUM_REQ*DATA_W-1:0] req_data,
   input  logic [NUM_REQ-1:0]        req_last,
   output logic [NUM_REQ-1:0]        req_ready,
   output logic [DATA_W-1:0]         tx_data,
   output logic                      tx_write,
   input  logic                      tx_busy,
   output logic [GW-1:0]             grant_id,
   output logic                      active,
   output logic                      burst_trunc
);

   localparam int CW = $clog2(MAX_BURST + 1);

   if (NUM_REQ < 2 || NUM_REQ > 8 || MAX_BURST < 1 || MAX_BURST > 255 ||
       GAP_CYCLES < 1 || GAP_CYCLES > 255) begin : g_param_chk
      $error("controller_uart_tx_arbiter: parameter out of range");
   end

`ifdef CONTROLLER_UART_TX_GAP_EN
   localparam int GCW = $clog2(GAP_CYCLES + 1);
   typedef enum logic [2:0] {S_IDLE, S_SEND, S_SETTLE, S_DRAIN, S_GAP} state_t;
   localparam state_t S_REL = S_GAP;
   logic [GCW-1:0] gap_q;
`else
   typedef enum logic [1:0] {S_IDLE, S_SEND, S_SETTLE, S_DRAIN} state_t;
   localparam state_t S_REL = S_IDLE;
`endif

   state_t            state_q, state_d;
   logic [GW-1:0]     ptr_q;
   logic [CW-1:0]     count_q;
   logic              last_q;
   logic              win_found;
   logic [GW-1:0]     win_id;
   logic [GW:0]       rr_idx;
   logic              accept;
   logic              release_g;
   logic              trunc;
   logic [DATA_W-1:0] data_arr [NUM_REQ];

   for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
      assign data_arr[i] = req_data[i*DATA_W +: DATA_W];
   end

   // First valid requester at or above the pointer, wrapping past NUM_REQ-1.
   always_comb begin
      win_found = 1'b0;
      win_id    = '0;
      rr_idx    = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         rr_idx = {1'b0, ptr_q} + (GW+1)'(i);
         if (rr_idx >= (GW+1)'(NUM_REQ))
            rr_idx = rr_idx - (GW+1)'(NUM_REQ);
         if (!win_found && req_valid[rr_idx[GW-1:0]]) begin
            win_found = 1'b1;
            win_id    = rr_idx[GW-1:0];
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      accept    = 1'b0;
      release_g = 1'b0;
      trunc     = 1'b0;
      req_ready = '0;
      unique case (state_q)
         S_IDLE: begin
            if (win_found)
               state_d = S_SEND;
         end
         S_SEND: begin
            if (req_valid[grant_id] && !tx_busy) begin
               accept              = 1'b1;
               req_ready[grant_id] = 1'b1;
               state_d             = S_SETTLE;
            end
         end
         // UART raises busy one cycle after the strobe, so skip one look.
         S_SETTLE: state_d = S_DRAIN;
         S_DRAIN: begin
            if (!tx_busy) begin
               if (last_q) begin
                  release_g = 1'b1;
                  state_d   = S_REL;
               end else if (count_q == CW'(MAX_BURST)) begin
                  release_g = 1'b1;
                  trunc     = 1'b1;
                  state_d   = S_REL;
               end else begin
                  state_d = S_SEND;
               end
            end
         end
`ifdef CONTROLLER_UART_TX_GAP_EN
         S_GAP: begin
            if (gap_q == GCW'(GAP_CYCLES - 1))
               state_d = S_IDLE;
         end
`endif
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         state_q <= S_IDLE;
      else
         state_q <= state_d;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tx_data     <= '0;
         tx_write    <= 1'b0;
         grant_id    <= '0;
         active      <= 1'b0;
         burst_trunc <= 1'b0;
         ptr_q       <= '0;
         count_q     <= '0;
         last_q      <= 1'b0;
      end else begin
         tx_write    <= accept;
         burst_trunc <= trunc;
         if (state_q == S_IDLE && win_found) begin
            grant_id <= win_id;
            active   <= 1'b1;
         end
         if (accept) begin
            tx_data <= data_arr[grant_id];
            count_q <= count_q + CW'(1);
            last_q  <= req_last[grant_id];
         end
         if (release_g) begin
            active  <= 1'b0;
            count_q <= '0;
            ptr_q   <= (grant_id == GW'(NUM_REQ - 1)) ? '0 : grant_id + GW'(1);
         end
      end
   end

`ifdef CONTROLLER_UART_TX_GAP_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         gap_q <= '0;
      else if (release_g)
         gap_q <= '0;
      else if (state_q == S_GAP)
         gap_q <= gap_q + GCW'(1);
   end
`endif

endmodule

// File: tb/tb_controller_uart_tx_arbiter.sv
// tb_controller_uart_tx_arbiter: table rows plus hand sequences for the UART TX arbiter.
// Requesters and UART are small behavioural models; expected bytes queue in order.
module tb_controller_uart_tx_arbiter;

   localparam int NR   = 2;
   localparam int DW   = 8;
   localparam int MB   = 4;
   localparam int GC   = 4;
   localparam int BUSY = 10;

   logic            clk = 1'b0;
   logic            reset = 1'b1;
   logic [NR-1:0]   req_valid = '0;
   logic [NR*DW-1:0] req_data = '0;
   logic [NR-1:0]   req_last = '0;
   logic [NR-1:0]   req_ready;
   logic [DW-1:0]   tx_data;
   logic            tx_write;
   logic            tx_busy;
   logic            grant_id;
   logic            active;
   logic            burst_trunc;

   controller_uart_tx_arbiter #(
      .NUM_REQ(NR), .DATA_W(DW), .MAX_BURST(MB), .GAP_CYCLES(GC)
   ) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
      .req_ready(req_ready), .tx_data(tx_data), .tx_write(tx_write),
      .tx_busy(tx_busy), .grant_id(grant_id), .active(active),
      .burst_trunc(burst_trunc)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // UART: busy from the cycle after the strobe for BUSY cycles
   int bcnt;
   always @(posedge clk or posedge reset) begin
      if (reset)         bcnt <= 0;
      else if (tx_write) bcnt <= BUSY;
      else if (bcnt != 0) bcnt <= bcnt - 1;
   end
   assign tx_busy = (bcnt != 0);

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
      end
   endtask

   logic [8:0] rq0[$];
   logic [8:0] rq1[$];
   logic [8:0] sb[$];
   logic [8:0] sb_e;
   logic [8:0] f0, f1;
   logic [1:0] nv;
   logic       pop0 = 0, pop1 = 0, hold0 = 0;
   int         txw_cnt = 0, trunc_cnt = 0;
   int         vcyc = 0, lat = -1;
   bit         want_lat = 0;

   // Monitor, then requester drive; handshake sampled 1ns after drive.
   always @(negedge clk) begin
      if (tx_write) begin
         txw_cnt++;
         if (want_lat) begin
            lat = cyc - vcyc;
            want_lat = 0;
         end
         if (sb.size() == 0)
            chk("unexpected_write", {23'd0, grant_id, tx_data}, 32'hdead);
         else begin
            sb_e = sb.pop_front();
            chk("tx_byte", {23'd0, grant_id, tx_data}, {23'd0, sb_e});
         end
      end
      if (burst_trunc) trunc_cnt++;
      if (req_ready != '0)
         chk("ready_onehot", {29'd0, req_ready, active}, {29'd0, 2'b01 << grant_id, 1'b1});
      if (pop0 && rq0.size() != 0) void'(rq0.pop_front());
      if (pop1 && rq1.size() != 0) void'(rq1.pop_front());
      pop0 = 0;
      pop1 = 0;
      f0 = (rq0.size() != 0) ? rq0[0] : 9'h0;
      f1 = (rq1.size() != 0) ? rq1[0] : 9'h0;
      nv = {rq1.size() != 0, (rq0.size() != 0) && !hold0};
      if (req_valid == 2'b00 && nv != 2'b00) vcyc = cyc;
      req_valid = nv;
      req_data  = {f1[7:0], f0[7:0]};
      req_last  = {f1[8], f0[8]};
      #1;
      if (req_valid[0] && req_ready[0]) pop0 = 1;
      if (req_valid[1] && req_ready[1]) pop1 = 1;
   end

   task automatic step();
      @(negedge clk);
      #2;
   endtask

   task automatic load(input int who, input logic [7:0] d, input logic last);
      if (who == 0) rq0.push_back({last, d});
      else          rq1.push_back({last, d});
   endtask

   task automatic expb(input int who, input logic [7:0] d);
      sb.push_back({who[0], d});
   endtask

   task automatic wait_done(input string nm);
      int t;
      t = 0;
      while (!(sb.size() == 0 && rq0.size() == 0 && rq1.size() == 0 &&
               !active && !tx_busy) && t < 3000) begin
         step();
         t++;
      end
      chk({nm, "_done"}, (t < 3000) ? 32'd1 : 32'd0, 32'd1);
      repeat (8) step();
   endtask

   task automatic wait_txw(input string nm, input int target);
      int t;
      t = 0;
      while (txw_cnt < target && t < 2000) begin
         step();
         t++;
      end
      chk({nm, "_txw_wait"}, (t < 2000) ? 32'd1 : 32'd0, 32'd1);
   endtask

   task automatic chk_reset_vals(input string nm);
      chk({nm, "_tx_write"},    {31'd0, tx_write},    32'd0);
      chk({nm, "_tx_data"},     {24'd0, tx_data},     32'd0);
      chk({nm, "_req_ready"},   {30'd0, req_ready},   32'd0);
      chk({nm, "_grant_id"},    {31'd0, grant_id},    32'd0);
      chk({nm, "_active"},      {31'd0, active},      32'd0);
      chk({nm, "_burst_trunc"}, {31'd0, burst_trunc}, 32'd0);
   endtask

   typedef struct {
      int          n0;
      logic [31:0] d0;
      int          n1;
      logic [31:0] d1;
      bit          last1;
      int          first;
      int          trunc;
   } vec_t;

   vec_t tbl[6];

   initial begin
      vec_t v;
      int   base, gch, idle, t;

      // pointer before each row: 0,1,1,1,0,0
      tbl[0] = '{3, 32'h000D5441, 0, 32'h0,        1'b1, 0, 0};
      tbl[1] = '{1, 32'h00000061, 1, 32'h00000071, 1'b1, 1, 0};
      tbl[2] = '{2, 32'h00006362, 2, 32'h00007372, 1'b1, 1, 0};
      tbl[3] = '{0, 32'h0,        4, 32'h77767574, 1'b0, 1, 1};
      tbl[4] = '{4, 32'h67666564, 1, 32'h00000078, 1'b1, 0, 0};
      tbl[5] = '{1, 32'h00000069, 1, 32'h00000079, 1'b1, 0, 0};

      repeat (3) step();
      chk_reset_vals("in_reset");
      reset = 1'b0;
      repeat (2) step();
      chk_reset_vals("after_reset");

      // contention from reset: r0 wins, then pointer wraps back to 0
      for (int rep = 0; rep < 2; rep++) begin
         expb(0, 8'hA0 + 8'(rep)); expb(0, 8'hA8 + 8'(rep));
         expb(1, 8'hB0 + 8'(rep)); expb(1, 8'hB8 + 8'(rep));
         load(1, 8'hB0 + 8'(rep), 0); load(1, 8'hB8 + 8'(rep), 1);
         load(0, 8'hA0 + 8'(rep), 0); load(0, 8'hA8 + 8'(rep), 1);
         wait_done($sformatf("contention%0d", rep));
      end

      for (int r = 0; r < 6; r++) begin
         v = tbl[r];
         trunc_cnt = 0;
         base = txw_cnt;
         lat = -1;
         want_lat = 1;
         if (v.first == 0)
            for (int k = 0; k < v.n0; k++) expb(0, v.d0[8*k +: 8]);
         for (int k = 0; k < v.n1; k++) expb(1, v.d1[8*k +: 8]);
         if (v.first != 0)
            for (int k = 0; k < v.n0; k++) expb(0, v.d0[8*k +: 8]);
         for (int k = 0; k < v.n0; k++) load(0, v.d0[8*k +: 8], k == v.n0 - 1);
         for (int k = 0; k < v.n1; k++) load(1, v.d1[8*k +: 8], v.last1 && k == v.n1 - 1);
         wait_done($sformatf("row%0d", r));
         chk($sformatf("row%0d_trunc", r), trunc_cnt, v.trunc);
         chk($sformatf("row%0d_writes", r), txw_cnt - base, v.n0 + v.n1);
         chk($sformatf("row%0d_latency", r), lat, 2);
      end

      // truncation with r0 waiting: r1 x4, trunc, r0, r1 resumes
      trunc_cnt = 0;
      for (int k = 1; k <= 4; k++) expb(1, 8'hE0 + 8'(k));
      expb(0, 8'hF1);
      expb(1, 8'hE5); expb(1, 8'hE6);
      for (int k = 1; k <= 6; k++) load(1, 8'hE0 + 8'(k), k == 6);
      t = 0;
      while (!(active && grant_id == 1'b1) && t < 100) begin step(); t++; end
      chk("trunc_grant_r1", {31'd0, grant_id}, 32'd1);
      load(0, 8'hF1, 1);
      wait_done("trunc");
      chk("trunc_pulses", trunc_cnt, 1);

      // stall: r0 holds grant while idle, r1 pending must not be served
      base = txw_cnt;
      expb(0, 8'h91); expb(0, 8'h92); expb(0, 8'h93); expb(1, 8'h94);
      load(0, 8'h91, 0); load(0, 8'h92, 0); load(0, 8'h93, 1);
      load(1, 8'h94, 1);
      wait_txw("stall", base + 1);
      hold0 = 1;
      base = txw_cnt;
      gch = 0;
      repeat (50) begin
         step();
         if (grant_id != 1'b0 || !active) gch++;
      end
      chk("stall_writes", txw_cnt - base, 0);
      chk("stall_grant_kept", gch, 0);
      hold0 = 0;
      wait_done("stall");

      // reset during DRAIN of r1's first byte (pointer is 1 at that point)
      base = txw_cnt;
      expb(0, 8'h11); expb(1, 8'h21);
      load(0, 8'h11, 1);
      load(1, 8'h21, 0); load(1, 8'h22, 1);
      wait_txw("rst_mid", base + 2);
      t = 0;
      while (!tx_busy && t < 20) begin step(); t++; end
      chk("rst_mid_in_drain", {31'd0, tx_busy}, 32'd1);
      reset = 1'b1;
      #1;
      chk_reset_vals("rst_mid");
      rq0.delete(); rq1.delete(); sb.delete();
      pop0 = 0; pop1 = 0;
      repeat (3) step();
      reset = 1'b0;
      base = txw_cnt;
      repeat (20) step();
      chk("rst_no_write", txw_cnt - base, 0);
      expb(0, 8'h31); expb(1, 8'h32);
      load(1, 8'h32, 1); load(0, 8'h31, 1);
      wait_done("post_reset");

`ifdef CONTROLLER_UART_TX_GAP_EN
      base = txw_cnt;
      expb(0, 8'h51); expb(0, 8'h52);
      load(0, 8'h51, 1); load(0, 8'h52, 1);
      wait_txw("gap", base + 1);
      t = 0;
      while (active && t < 100) begin step(); t++; end
      idle = 0;
      while (!active && t < 200) begin idle++; step(); t++; end
      chk("gap_idle_ge4", (idle >= GC) ? 32'd1 : 32'd0, 32'd1);
      wait_done("gap");
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: got timeout, want completion");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/controller_uart_tx_arbiter.md
Name: controller_uart_tx_arbiter

Overview:
- Shares one UART transmitter between NUM_REQ byte-stream requesters, e.g. firmware PIO path and the hardware gauge/poll engine.
- Round-robin arbitration at message granularity: a granted requester keeps the UART until it sends a byte flagged last, or until MAX_BURST bytes have gone out.
- Drives the UART write strobe and data, and paces each byte against the UART busy flag.
- Sits between the requesters and the UART core; replaces direct software toggling of the UART write-control lines.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- DATA_W, 8, byte width.
- MAX_BURST, 16, maximum bytes per grant before forced release (1..255).
- GAP_CYCLES, 4, idle cycles between messages; used only with the optional feature (1..255).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester byte available.
- req_data  in  NUM_REQ*DATA_W  per-requester byte; requester i occupies bits [i*DATA_W +: DATA_W].
- req_last  in  NUM_REQ  byte is the final byte of its message.
- req_ready  out  NUM_REQ  one-hot, one-cycle accept of the granted requester's byte.
- tx_data  out  DATA_W  byte to the UART, registered.
- tx_write  out  1  one-cycle write strobe to the UART, registered.
- tx_busy  in  1  UART shifting; high from the cycle after tx_write until the stop bit completes.
- grant_id  out  clog2(NUM_REQ), min 1  current or last granted requester.
- active  out  1  a message is in progress.
- burst_trunc  out  1  one-cycle pulse when a grant is released by MAX_BURST without last.

Behaviour:
- Reset (asynchronous assert, synchronous release effect):
  - tx_write=0, tx_data=0, req_ready=0, grant_id=0, active=0, burst_trunc=0.
  - Round-robin pointer=0, so requester 0 has top priority first.
  - Byte count=0, FSM=IDLE.
- IDLE:
  - If any req_valid is set, grant the first valid requester searching from pointer upward with wrap.
  - Register grant_id and set active=1 on the next edge; go to SEND.
- SEND (granted requester g):
  - When req_valid[g]=1 and tx_busy=0: req_ready[g]=1 combinationally this cycle.
  - On the same edge, tx_data<=req_data[g], tx_write<=1, count++, then go to SETTLE.
  - If req_valid[g]=0, hold the grant indefinitely; no other requester is served mid-message.
- SETTLE:
  - Lasts one cycle; tx_busy is ignored because the UART raises it one cycle after the strobe. tx_write returns to 0.
  - Go to DRAIN.
- DRAIN:
  - Wait for tx_busy=0, then decide.
  - If the accepted byte had req_last=1: release. active<=0, pointer<=g+1 mod NUM_REQ, count<=0, go to IDLE.
  - Else if count==MAX_BURST: release as above and pulse burst_trunc.
  - Else return to SEND.
- Handshake rules:
  - A byte is transferred only when req_valid&req_ready; exactly one tx_write per transfer.
  - req_ready is never high for a non-granted requester.
  - req_ready is never high in IDLE, SETTLE or DRAIN.
- Latency:
  - Request to first tx_write: 2 cycles from IDLE with tx_busy=0 (grant edge, then SEND edge).
  - Byte-to-byte minimum: SEND, SETTLE, DRAIN, giving 3 cycles plus UART busy time.
- Boundary conditions:
  - Back-to-back messages from the same requester are re-arbitrated; the pointer ensures other pending requesters win first.
  - Simultaneous requests: lowest index at or above the pointer wins.
  - MAX_BURST=1 releases after every byte (byte-level round robin).
  - A byte with req_last=1 at count==MAX_BURST releases normally; burst_trunc is not pulsed.
  - Count width is clog2(MAX_BURST+1); it never wraps because release happens at MAX_BURST.
  - tx_busy high at grant time: SEND waits and req_ready stays low.
  - Reset mid-message abandons the message immediately: no further tx_write, grant lost, pointer=0. Any byte already handed to the UART is the UART's concern.

Optional Feature:
- Macro: CONTROLLER_UART_TX_GAP_EN.
- Defined: a GAP state is inserted after every release (last or truncation).
  - Counts GAP_CYCLES cycles with active=0 before returning to IDLE.
  - req_valid is ignored during GAP; gives the ECU/ELM-side parser inter-message idle time.
- Undefined: release goes straight to IDLE; the GAP state, its counter and all GAP_CYCLES logic are absent.

Test Plan:
- Single message: requester 0 sends bytes 0x41,0x54,0x0D with last on 0x0D; UART busy 10 cycles/byte.
  - Expect exactly 3 tx_write pulses with tx_data 0x41,0x54,0x0D, each after tx_busy falls.
  - Expect active to drop after the third, and the pointer to become 1.
- Contention: both requesters valid from reset, each with a 2-byte message.
  - Expect the order r0,r0,r1,r1.
  - Repeat immediately: expect r1 first is not granted; the order is r0 then r1 again, because the pointer wraps to 0 after r1.
- Truncation: MAX_BURST=4, requester 1 streams 6 bytes without last while requester 0 waits.
  - Expect 4 bytes from r1, a burst_trunc pulse, then r0 served, then r1 resumes with bytes 5 and 6.
- Stall: the granted requester drops req_valid for 50 cycles mid-message while the other is valid.
  - Expect no tx_write and no grant change; the message resumes when valid returns.
- Reset mid-byte: assert reset during DRAIN.
  - Expect all outputs at reset values in the same cycle and no tx_write after release.
  - A new request is then served from r0.
- With CONTROLLER_UART_TX_GAP_EN and GAP_CYCLES=4: two back-to-back messages.
  - Expect at least 4 cycles of active=0 between the last tx_write of one message and the first grant edge of the next.
